// File: rtl/multi_port_memory_w_mask.sv
// ---------------------------------------------------------------------------
// multi_port_memory_w_mask
//
// Shared byte-masked memory array serving NUM_CH independent request
// channels. Each channel runs its own IDLE/READ/WRITE FSM with a 4-bit
// down-counter, so every request completes exactly DELAY edges after the
// edge that accepted it. Completion produces a one-cycle resp pulse; reads
// return the masked bytes on rdata during that pulse (unmasked bytes and
// all non-resp cycles read as zero). Writes update only enabled bytes at the
// completion edge. On same-edge writes to one byte the lowest channel wins;
// same-edge reads observe the pre-write contents.
//
// Optional feature macro: MEM_PROTOCOL_CHECK_EN
//   defined   -> sticky protocol-error detector drives 'error'
//   undefined -> 'error' tied low, no checker logic present
//
// Ports
//   clk    in   1                sole clock, rising edge
//   rst    in   1                asynchronous active-high reset
//   addr   in   NUM_CH x 32      byte address per channel
//   rmask  in   NUM_CH x DATA_W/8 byte read enables (nonzero = read)
//   wmask  in   NUM_CH x DATA_W/8 byte write enables (nonzero = write)
//   wdata  in   NUM_CH x DATA_W  write data
//   rdata  out  NUM_CH x DATA_W  read data, valid while resp high
//   resp   out  NUM_CH           one-cycle completion pulse
//   error  out  1                sticky protocol-error flag
// ---------------------------------------------------------------------------
module multi_port_memory_w_mask #(
   parameter int NUM_CH     = 2,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int DELAY      = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0][31:0]          addr,
   input  logic [NUM_CH-1:0][DATA_W/8-1:0]  rmask,
   input  logic [NUM_CH-1:0][DATA_W/8-1:0]  wmask,
   input  logic [NUM_CH-1:0][DATA_W-1:0]    wdata,
   output logic [NUM_CH-1:0][DATA_W-1:0]    rdata,
   output logic [NUM_CH-1:0]                resp,
   output logic                             error
);

   localparam int NB    = DATA_W / 8;
   localparam int BSH   = $clog2(NB);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_LOAD = 4'(DELAY - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t                          state_r     [NUM_CH];
   state_t                          state_nxt_s [NUM_CH];
   logic [3:0]                      cnt_r       [NUM_CH];
   logic [3:0]                      cnt_nxt_s   [NUM_CH];
   logic [DEPTH_LOG2-1:0]           widx_s      [NUM_CH];
   logic [NUM_CH-1:0]               done_rd_s;
   logic [NUM_CH-1:0]               done_wr_s;
   logic [NUM_CH-1:0][DATA_W-1:0]   rd_word_s;
   logic [NUM_CH-1:0][DATA_W-1:0]   rdata_r;
   logic [NUM_CH-1:0]               resp_r;
   logic [DATA_W-1:0]               mem_r       [DEPTH];
   logic                            addr_unused_s;

   // Address bits outside the word index are deliberately ignored (aliasing).
   assign addr_unused_s = ^addr;

   assign rdata = rdata_r;
   assign resp  = resp_r;

   // Per-channel next-state, completion strobes, word index and masked read data.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         state_nxt_s[c] = state_r[c];
         cnt_nxt_s[c]   = cnt_r[c];
         done_rd_s[c]   = 1'b0;
         done_wr_s[c]   = 1'b0;
         widx_s[c]      = addr[c][DEPTH_LOG2+BSH-1:BSH];
         for (int b = 0; b < NB; b++) begin
            rd_word_s[c][8*b +: 8] = rmask[c][b] ? mem_r[widx_s[c]][8*b +: 8] : 8'h00;
         end
         case (state_r[c])
            ST_IDLE: begin
               // Write has priority when both masks are nonzero.
               if (|wmask[c]) begin
                  state_nxt_s[c] = ST_WRITE;
                  cnt_nxt_s[c]   = CNT_LOAD;
               end else if (|rmask[c]) begin
                  state_nxt_s[c] = ST_READ;
                  cnt_nxt_s[c]   = CNT_LOAD;
               end else begin
                  state_nxt_s[c] = ST_IDLE;
                  cnt_nxt_s[c]   = 4'd0;
               end
            end
            ST_READ: begin
               if (cnt_r[c] == 4'd0) begin
                  state_nxt_s[c] = ST_IDLE;
                  done_rd_s[c]   = 1'b1;
               end else begin
                  cnt_nxt_s[c] = cnt_r[c] - 4'd1;
               end
            end
            ST_WRITE: begin
               if (cnt_r[c] == 4'd0) begin
                  state_nxt_s[c] = ST_IDLE;
                  done_wr_s[c]   = 1'b1;
               end else begin
                  cnt_nxt_s[c] = cnt_r[c] - 4'd1;
               end
            end
            default: begin
               state_nxt_s[c] = ST_IDLE;
               cnt_nxt_s[c]   = 4'd0;
            end
         endcase
      end
   end

   // FSM state, counters and registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_r[c] <= ST_IDLE;
            cnt_r[c]   <= 4'd0;
         end
         resp_r  <= '0;
         rdata_r <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_r[c]   <= state_nxt_s[c];
            cnt_r[c]     <= cnt_nxt_s[c];
            resp_r[c]    <= done_rd_s[c] | done_wr_s[c];
            rdata_r[c]   <= done_rd_s[c] ? rd_word_s[c] : {DATA_W{1'b0}};
         end
      end
   end

   // Array write port; descending channel order lets the lowest channel's
   // byte win on a same-edge collision. The array is never reset; in-flight
   // writes are cancelled because reset clears the FSM states that gate them.
   always_ff @(posedge clk) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (done_wr_s[c]) begin
            for (int b = 0; b < NB; b++) begin
               if (wmask[c][b]) begin
                  mem_r[widx_s[c]][8*b +: 8] <= wdata[c][8*b +: 8];
               end
            end
         end
      end
   end

`ifdef MEM_PROTOCOL_CHECK_EN
   logic [NUM_CH-1:0][31:0]   addr_hold_r;
   logic [NUM_CH-1:0][NB-1:0] mask_hold_r;
   logic                      error_r;
   logic                      viol_s;
   logic [NB-1:0]             act_mask_s;
   logic                      any_req_s;

   // Combine every per-channel protocol violation into one strobe.
   always_comb begin
      viol_s     = 1'b0;
      act_mask_s = '0;
      any_req_s  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         act_mask_s = (state_r[c] == ST_WRITE) ? wmask[c] : rmask[c];
         any_req_s  = (|rmask[c]) || (|wmask[c]);
         viol_s = viol_s | $isunknown(rmask[c]) | $isunknown(wmask[c]);
         viol_s = viol_s | ((|rmask[c]) && (|wmask[c]));
         viol_s = viol_s | (any_req_s && ($isunknown(addr[c]) ||
                                          (addr[c][BSH-1:0] != {BSH{1'b0}})));
         viol_s = viol_s | ((state_r[c] != ST_IDLE) &&
                            ((addr[c] != addr_hold_r[c]) ||
                             (act_mask_s != mask_hold_r[c])));
      end
   end

   // Capture request fields while idle so a busy channel can be compared
   // against what it was accepted with; error is sticky until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_hold_r <= '0;
         mask_hold_r <= '0;
         error_r     <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (state_r[c] == ST_IDLE) begin
               addr_hold_r[c] <= addr[c];
               mask_hold_r[c] <= (|wmask[c]) ? wmask[c] : rmask[c];
            end
         end
         error_r <= error_r | viol_s;
      end
   end

   assign error = error_r;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_multi_port_memory_w_mask.sv
module tb_multi_port_memory_w_mask;

   localparam int DA = 3;
   localparam int DB = 1;
`ifdef MEM_PROTOCOL_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0][31:0] addr_a, wdata_a, rdata_a, addr_b, wdata_b, rdata_b;
   logic [1:0][3:0]  rmask_a, wmask_a, rmask_b, wmask_b;
   logic [1:0]       resp_a, resp_b;
   logic             error_a, error_b;

   multi_port_memory_w_mask #(.NUM_CH(2), .DATA_W(32), .DEPTH_LOG2(10), .DELAY(DA)) u_dut_a (
      .clk(clk), .rst(rst), .addr(addr_a), .rmask(rmask_a), .wmask(wmask_a),
      .wdata(wdata_a), .rdata(rdata_a), .resp(resp_a), .error(error_a));

   multi_port_memory_w_mask #(.NUM_CH(2), .DATA_W(32), .DEPTH_LOG2(10), .DELAY(DB)) u_dut_b (
      .clk(clk), .rst(rst), .addr(addr_b), .rmask(rmask_b), .wmask(wmask_b),
      .wdata(wdata_b), .rdata(rdata_b), .resp(resp_b), .error(error_b));

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t qa [2][$];
   exp_t qb [2][$];
   exp_t ea, eb;

   always @(posedge clk) cyc++;

   // Scoreboard monitor: every resp pops the channel's queue; rdata must be 0 otherwise.
   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (resp_a[c]) begin
            if (qa[c].size() == 0) begin
               errors++;
               $display("FAIL a_unexpected_resp ch%0d: resp at cyc %0d, none expected", c, cyc);
            end else begin
               ea = qa[c].pop_front();
               if (ea.cyc != cyc || rdata_a[c] !== ea.data) begin
                  errors++;
                  $display("FAIL a_resp ch%0d: got cyc %0d rdata %h, want cyc %0d rdata %h",
                           c, cyc, rdata_a[c], ea.cyc, ea.data);
               end
            end
         end else if (rdata_a[c] !== 32'h0) begin
            errors++;
            $display("FAIL a_rdata_idle ch%0d: got %h want 00000000", c, rdata_a[c]);
         end
         checks++;
         if (resp_b[c]) begin
            if (qb[c].size() == 0) begin
               errors++;
               $display("FAIL b_unexpected_resp ch%0d: resp at cyc %0d, none expected", c, cyc);
            end else begin
               eb = qb[c].pop_front();
               if (eb.cyc != cyc || rdata_b[c] !== eb.data) begin
                  errors++;
                  $display("FAIL b_resp ch%0d: got cyc %0d rdata %h, want cyc %0d rdata %h",
                           c, cyc, rdata_b[c], eb.cyc, eb.data);
               end
            end
         end else if (rdata_b[c] !== 32'h0) begin
            errors++;
            $display("FAIL b_rdata_idle ch%0d: got %h want 00000000", c, rdata_b[c]);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic clr_a();
      addr_a = '0; rmask_a = '0; wmask_a = '0; wdata_a = '0;
   endtask

   task automatic clr_b();
      addr_b = '0; rmask_b = '0; wmask_b = '0; wdata_b = '0;
   endtask

   task automatic start();
      @(posedge clk);
      #1;
   endtask

   // Present a request on DUT A; optionally queue its expected response.
   task automatic req_a(input int ch, input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd,
                        input logic [31:0] exp_d, input bit push);
      addr_a[ch] = a; rmask_a[ch] = rm; wmask_a[ch] = wm; wdata_a[ch] = wd;
      if (push) qa[ch].push_back('{cyc: cyc + 1 + DA, data: exp_d});
   endtask

   task automatic req_b(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input logic [31:0] exp_d);
      addr_b[0] = a; rmask_b[0] = rm; wmask_b[0] = wm; wdata_b[0] = wd;
      qb[0].push_back('{cyc: cyc + 1 + DB, data: exp_d});
   endtask

   // Hold DUT A inputs through the completion edge, then release.
   task automatic finish_a();
      repeat (DA + 1) @(posedge clk);
      #1;
      clr_a();
   endtask

   logic [31:0] b_addr [3];
   logic [31:0] b_data [3];

   initial begin
      b_addr[0] = 32'h0000_0000; b_addr[1] = 32'h0000_0004; b_addr[2] = 32'h0000_0008;
      b_data[0] = 32'h0102_0304; b_data[1] = 32'h0506_0708; b_data[2] = 32'h090A_0B0C;
      rst = 1'b1;
      clr_a();
      clr_b();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_resp_a", {62'd0, resp_a}, 64'd0);
      chk("reset_rdata_a", rdata_a, 64'd0);
      chk("reset_error_a", {63'd0, error_a}, 64'd0);
      #2 rst = 1'b0;

      // Full-word round trip
      start(); req_a(0, 32'h100, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1); finish_a();
      start(); req_a(0, 32'h100, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1); finish_a();
      // Byte-lane masking: bytes 0 and 2 replaced, read bytes 0..1 only
      start(); req_a(0, 32'h100, 4'h0, 4'h5, 32'h11223344, 32'h0, 1'b1); finish_a();
      start(); req_a(0, 32'h100, 4'h3, 4'h0, 32'h0, 32'h0000BE44, 1'b1); finish_a();
      start(); req_a(0, 32'h100, 4'hF, 4'h0, 32'h0, 32'hDE22BE44, 1'b1); finish_a();
      // Address aliasing above the word index
      start(); req_a(1, 32'h1100, 4'hF, 4'h0, 32'h0, 32'hDE22BE44, 1'b1); finish_a();
      // Same-edge write contention: channel 0 wins
      start();
      req_a(0, 32'h200, 4'h0, 4'hF, 32'hAAAAAAAA, 32'h0, 1'b1);
      req_a(1, 32'h200, 4'h0, 4'hF, 32'h55555555, 32'h0, 1'b1);
      finish_a();
      start(); req_a(1, 32'h200, 4'hF, 4'h0, 32'h0, 32'hAAAAAAAA, 1'b1); finish_a();

      // Reset mid-write: cell primed with 0, interrupted write must not land
      start(); req_a(1, 32'h300, 4'h0, 4'hF, 32'h0, 32'h0, 1'b1); finish_a();
      start(); req_a(1, 32'h300, 4'h0, 4'hF, 32'h12345678, 32'h0, 1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_async_resp_a", {62'd0, resp_a}, 64'd0);
      @(posedge clk);
      #1 clr_a();
      @(posedge clk);
      #3 rst = 1'b0;
      start(); req_a(1, 32'h300, 4'hF, 4'h0, 32'h0, 32'h0, 1'b1); finish_a();
      chk("error_legal_traffic", {63'd0, error_a}, 64'd0);

      // Protocol check (a): misaligned read address
      start(); req_a(0, 32'h102, 4'hF, 4'h0, 32'h0, 32'hDE22BE44, 1'b1); finish_a();
      chk("error_misaligned", {63'd0, error_a}, {63'd0, ERR_EN});
      repeat (3) @(posedge clk);
      #1 chk("error_sticky", {63'd0, error_a}, {63'd0, ERR_EN});
      #2 rst = 1'b1;
      #2 chk("error_cleared", {63'd0, error_a}, 64'd0);
      #2 rst = 1'b0;
      // Protocol check (b): address changes to an alias while the read is busy
      start(); req_a(0, 32'h100, 4'hF, 4'h0, 32'h0, 32'hDE22BE44, 1'b1);
      @(posedge clk);
      #1 addr_a[0] = 32'h1100;
      repeat (DA) @(posedge clk);
      #1 clr_a();
      chk("error_addr_change", {63'd0, error_a}, {63'd0, ERR_EN});

      // DELAY=1 back-to-back: writes, then reads issued in each resp cycle
      start();
      for (int i = 0; i < 3; i++) begin
         req_b(b_addr[i], 4'h0, 4'hF, b_data[i], 32'h0);
         repeat (2) @(posedge clk);
         #1;
      end
      clr_b();
      start();
      for (int i = 0; i < 3; i++) begin
         req_b(b_addr[i], 4'hF, 4'h0, 32'h0, b_data[i]);
         repeat (2) @(posedge clk);
         #1;
      end
      clr_b();
      repeat (4) @(posedge clk);
      #1;

      for (int c = 0; c < 2; c++) begin
         chk($sformatf("a_queue_drained_ch%0d", c), 64'(qa[c].size()), 64'd0);
         chk($sformatf("b_queue_drained_ch%0d", c), 64'(qb[c].size()), 64'd0);
      end
      chk("b_error_idle", {63'd0, error_b}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
